// File: rtl/hdmi_tx_pkg.sv
// Shared definitions for the HDMI TX clocking/reset path: sequencer state
// encodings, default PLL timing constants and debug counter width.
package hdmi_tx_pkg;

  typedef enum logic [1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  // Defaults assume a 50 MHz reference clock.
  localparam int unsigned DEF_PLL_RST_CYCLES      = 10;      // 200 ns
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 500000;  // 10 ms
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 5000;    // 100 us
  localparam int unsigned DEF_SYNC_STAGES         = 2;

  localparam int unsigned LOCK_LOSS_W = 8;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hdmi_sync_bit.sv
// Single-bit multi-flop synchroniser with asynchronous active-low clear.
module hdmi_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_chain <= '0;
    else          r_chain <= {r_chain[STAGES-2:0], i_d};
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/hdmi_tx_pll_reset_seq.sv
// HDMI TX PLL reset sequencer and lock supervisor.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   RESET_PLL | pll_rst held high for PLL_RST_CYCLES
//   WAIT_LOCK | PLL released, waiting for lock; retry after timeout
//   STABLE    | lock seen, must hold for LOCK_STABLE_CYCLES before release
//   RUN       | TX datapath released; any lock loss re-resets the PLL
//
// Outputs are registered and decoded from the next state, so they change on
// the same edge that enters a state.
module hdmi_tx_pll_reset_seq
  import hdmi_tx_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  input  logic                   locked,
  input  logic                   soft_rst,
  output logic                   pll_rst,
  output logic                   tx_rst_n,
  output logic                   ready,
  output logic [1:0]             state,
  output logic [LOCK_LOSS_W-1:0] lock_loss_cnt
);

  localparam int unsigned CNT_MAX = max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] C_PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  localparam logic [1:0] S_RESET_PLL = ST_RESET_PLL;
  localparam logic [1:0] S_WAIT_LOCK = ST_WAIT_LOCK;
  localparam logic [1:0] S_STABLE    = ST_STABLE;
  localparam logic [1:0] S_RUN       = ST_RUN;

  localparam logic [LOCK_LOSS_W-1:0] LLC_MAX = '1;

  logic                   w_locked_s;
  logic [1:0]             w_state_nxt;
  logic                   w_llc_inc;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_pll_rst;
  logic                   r_tx_rst_n;
  logic                   r_ready;
  logic [LOCK_LOSS_W-1:0] r_llc;

  hdmi_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .i_clk   (refclk),
    .i_rst_n (rst_n),
    .i_d     (locked),
    .o_q     (w_locked_s)
  );

  // Next-state selection; soft_rst overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (soft_rst) begin
      w_state_nxt = S_RESET_PLL;
    end else begin
      case (r_state)
        S_RESET_PLL: if (r_cnt == C_PLL_LAST) w_state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK: begin
          if (w_locked_s)                   w_state_nxt = S_STABLE;
          else if (r_cnt == C_TIMEOUT_LAST) w_state_nxt = S_RESET_PLL;
        end
        S_STABLE: begin
          if (!w_locked_s)                 w_state_nxt = S_WAIT_LOCK;
          else if (r_cnt == C_STABLE_LAST) w_state_nxt = S_RUN;
        end
        S_RUN:   if (!w_locked_s) w_state_nxt = S_RESET_PLL;
        default: w_state_nxt = S_RESET_PLL;
      endcase
    end
  end

  // Only a genuine lock loss in RUN counts; a coincident soft_rst masks it.
  always_comb begin
    w_llc_inc = (r_state == S_RUN) && !w_locked_s && !soft_rst && (r_llc != LLC_MAX);
  end

  // State, shared cycle counter, debug counter and next-state-decoded outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RESET_PLL;
      r_cnt      <= '0;
      r_pll_rst  <= 1'b1;
      r_tx_rst_n <= 1'b0;
      r_ready    <= 1'b0;
      r_llc      <= '0;
    end else begin
      r_state <= w_state_nxt;
      // soft_rst while already in RESET_PLL must still restart the count.
      if (soft_rst || (w_state_nxt != r_state)) r_cnt <= '0;
      else if (r_state != S_RUN)                r_cnt <= r_cnt + CNT_W'(1);
      r_pll_rst  <= (w_state_nxt == S_RESET_PLL);
      r_tx_rst_n <= (w_state_nxt == S_RUN);
      r_ready    <= (w_state_nxt == S_RUN);
      if (w_llc_inc) r_llc <= r_llc + LOCK_LOSS_W'(1);
    end
  end

  assign pll_rst       = r_pll_rst;
  assign tx_rst_n      = r_tx_rst_n;
  assign ready         = r_ready;
  assign state         = r_state;
  assign lock_loss_cnt = r_llc;

endmodule

// File: tb/tb_hdmi_tx_pll_reset_seq.sv
// Testbench for hdmi_tx_pll_reset_seq: directed vector table, async reset,
// randomized lock/soft_rst activity against a behavioural model, and
// lock-loss counter saturation.
module tb_hdmi_tx_pll_reset_seq;

  localparam int P_RST  = 4;
  localparam int P_TO   = 64;
  localparam int P_STB  = 16;
  localparam int P_SYNC = 2;

  logic       refclk = 1'b0;
  logic       rst_n  = 1'b1;
  logic       locked = 1'b0;
  logic       soft_rst = 1'b0;
  logic       pll_rst;
  logic       tx_rst_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lock_loss_cnt;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  always #5 refclk = ~refclk;

  hdmi_tx_pll_reset_seq #(
    .PLL_RST_CYCLES      (P_RST),
    .LOCK_TIMEOUT_CYCLES (P_TO),
    .LOCK_STABLE_CYCLES  (P_STB),
    .SYNC_STAGES         (P_SYNC)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .locked        (locked),
    .soft_rst      (soft_rst),
    .pll_rst       (pll_rst),
    .tx_rst_n      (tx_rst_n),
    .ready         (ready),
    .state         (state),
    .lock_loss_cnt (lock_loss_cnt)
  );

  logic [12:0] dut_vec;
  assign dut_vec = {pll_rst, tx_rst_n, ready, state, lock_loss_cnt};

  function automatic logic [12:0] mk(input bit pll, input bit txn, input bit rdy,
                                     input int st, input int llc);
    return {pll, txn, rdy, st[1:0], llc[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: locked is seen P_SYNC edges late (queue delay line);
  // each phase owns a countdown of the cycles it may still spend.
  int m_phase = 0;
  int m_left  = P_RST;
  int m_llc   = 0;
  bit m_ls;
  bit m_dly[$];

  function automatic int dur(input int p);
    case (p)
      0:       return P_RST;
      1:       return P_TO;
      2:       return P_STB;
      default: return 0;
    endcase
  endfunction

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = P_RST;
      m_llc   = 0;
      m_dly.delete();
      for (int i = 0; i < P_SYNC; i++) m_dly.push_back(1'b0);
    end else begin
      m_ls = m_dly.pop_front();
      m_dly.push_back(locked);
      if (soft_rst) begin
        m_phase = 0; m_left = dur(0);
      end else if (m_phase == 0) begin
        m_left--;
        if (m_left == 0) begin m_phase = 1; m_left = dur(1); end
      end else if (m_phase == 1) begin
        if (m_ls) begin m_phase = 2; m_left = dur(2); end
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = 0; m_left = dur(0); end
        end
      end else if (m_phase == 2) begin
        if (!m_ls) begin m_phase = 1; m_left = dur(1); end
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = 3; m_left = 0; end
        end
      end else begin
        if (!m_ls) begin
          if (m_llc < 255) m_llc++;
          m_phase = 0; m_left = dur(0);
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge refclk) begin
    if (mon_en && rst_n)
      chk("model", 32'(dut_vec),
          32'(mk(m_phase == 0, m_phase == 3, m_phase == 3, m_phase, m_llc)));
  end

  typedef struct {
    bit          lk;
    bit          sr;
    int          n;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit lk, input bit sr, input int n, input bit pll,
                     input bit txn, input bit rdy, input int st, input int llc);
    vec_t v;
    v.lk = lk; v.sr = sr; v.n = n; v.exp = mk(pll, txn, rdy, st, llc);
    vecs.push_back(v);
  endtask

  task automatic wait_state(input int st, input int limit, input string name);
    int k;
    k = 0;
    while (state !== 2'(st) && k < limit) begin
      @(negedge refclk);
      k++;
    end
    chk(name, 32'(state), 32'(st));
  endtask

  task automatic wait_ready(input int limit);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < limit) begin
      @(negedge refclk);
      k++;
    end
    chk("wait_ready", 32'(ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //  lk sr  n  pll txn rdy st llc
    add(0, 0,  0, 1,  0,  0,  0, 0);  // reset state
    add(0, 0,  3, 1,  0,  0,  0, 0);
    add(0, 0,  1, 0,  0,  0,  1, 0);  // pll_rst was high 4 cycles
    add(0, 0, 63, 0,  0,  0,  1, 0);
    add(0, 0,  1, 1,  0,  0,  0, 0);  // timeout after 64 -> retry
    add(0, 0,  4, 0,  0,  0,  1, 0);
    add(1, 0,  1, 0,  0,  0,  1, 0);  // locked rises before edge j
    add(1, 0,  1, 0,  0,  0,  1, 0);
    add(1, 0,  1, 0,  0,  0,  2, 0);  // STABLE at j+2
    add(1, 0, 15, 0,  0,  0,  2, 0);
    add(1, 0,  1, 0,  1,  1,  3, 0);  // RUN at j+18
    add(0, 0,  1, 0,  1,  1,  3, 0);  // locked falls before edge j
    add(0, 0,  1, 0,  1,  1,  3, 0);
    add(0, 0,  1, 1,  0,  0,  0, 1);  // reset at j+2, count 1
    add(1, 0,  4, 0,  0,  0,  1, 1);
    add(1, 0,  1, 0,  0,  0,  2, 1);
    add(1, 0, 10, 0,  0,  0,  2, 1);  // cnt=10 in STABLE
    add(0, 0,  3, 0,  0,  0,  1, 1);  // 3-cycle dropout -> WAIT_LOCK
    add(1, 0,  2, 0,  0,  0,  1, 1);
    add(1, 0,  1, 0,  0,  0,  2, 1);
    add(1, 0, 15, 0,  0,  0,  2, 1);  // full 16 cycles needed again
    add(1, 0,  1, 0,  1,  1,  3, 1);
    add(0, 0,  2, 0,  1,  1,  3, 1);
    add(0, 1,  1, 1,  0,  0,  0, 1);  // soft_rst coincides with lock loss
    add(0, 1, 19, 1,  0,  0,  0, 1);  // soft_rst held 20 cycles
    add(0, 0,  3, 1,  0,  0,  0, 1);
    add(0, 0,  1, 0,  0,  0,  1, 1);  // 4 more cycles after release

    #1 rst_n = 1'b0;
    repeat (3) @(negedge refclk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    foreach (vecs[i]) begin
      locked   = vecs[i].lk;
      soft_rst = vecs[i].sr;
      repeat (vecs[i].n) @(negedge refclk);
      chk($sformatf("vec%0d", i), 32'(dut_vec), 32'(vecs[i].exp));
    end

    // Async reset between edges while in STABLE.
    locked = 1'b1;
    wait_state(2, 200, "reach_stable");
    @(posedge refclk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 32'(dut_vec), 32'(mk(1, 0, 0, 0, 0)));
    @(negedge refclk);
    rst_n = 1'b1;

    // Randomized lock activity with occasional soft_rst pulses.
    for (int s = 0; s < 150; s++) begin
      int hold;
      hold     = int'($urandom_range(1, 60));
      locked   = ($urandom_range(0, 9) < 7);
      soft_rst = ($urandom_range(0, 15) == 0);
      @(negedge refclk);
      soft_rst = 1'b0;
      repeat (hold - 1) @(negedge refclk);
    end

    // Lock-loss counter saturation.
    locked = 1'b0;
    @(negedge refclk);
    rst_n = 1'b0;
    @(negedge refclk);
    rst_n  = 1'b1;
    locked = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wait_ready(200);
      locked = 1'b0;
      repeat (2) @(negedge refclk);
      chk("ready_j1", 32'(ready), 32'd1);
      @(negedge refclk);
      chk("drop_j2", 32'({ready, tx_rst_n, pll_rst}), 32'b001);
      chk("llc", 32'(lock_loss_cnt), 32'((i + 1 > 255) ? 255 : i + 1));
      locked = 1'b1;
    end
    chk("llc_sat", 32'(lock_loss_cnt), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
